rf_writeback_arbiter: RTL and testbench

- Shares the single register-file write port between two writeback sources: ALU results and load-unit results.
- Keeps a per-register busy scoreboard for outstanding loads. Decode uses it for RAW hazard stalls and to throttle load issue.
- Sits between execute/memory writeback and the register file write interface (reg_write, write_index, write_data).

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/rf_writeback_arbiter_if.sv | 48 ++++
 rtl/rf_writeback_arbiter_scoreboard.sv | 72 +++++++
 rtl/rf_writeback_arbiter.sv | 76 +++++++
 tb/tb_rf_writeback_arbiter.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cpu_pkg : shared CPU types for the writeback path and register scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
package cpu_pkg;

    localparam int CPU_NUM_REGS = 32;
    localparam int CPU_ADDR_W   = 5;
    localparam int CPU_DATA_W   = 32;
    localparam int CPU_MAX_LD   = 4;

    typedef logic [CPU_DATA_W-1:0] word_t;
    typedef logic [CPU_ADDR_W-1:0] regidx_t;

    typedef enum logic [0:0] {
        WB_LD  = 1'b0,
        WB_ALU = 1'b1
    } wb_src_t;

    typedef struct packed {
        logic    valid;
        regidx_t index;
        word_t   data;
    } wb_req_t;

endpackage
`default_nettype wire

// File: rtl/rf_writeback_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_writeback_arbiter_if : writeback requests, load issue/hazard and RF write
// Rev 1.0
// ---------------------------------------------------------------------------
interface rf_writeback_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_index;
    logic [DATA_W-1:0] alu_data;

    logic              ld_valid;
    logic              ld_ready;
    logic [ADDR_W-1:0] ld_index;
    logic [DATA_W-1:0] ld_data;

    logic              issue_valid;
    logic [ADDR_W-1:0] issue_rd;
    logic              issue_ready;
    logic [ADDR_W-1:0] chk_index1;
    logic [ADDR_W-1:0] chk_index2;
    logic              hazard;

    logic              rf_reg_write;
    logic [ADDR_W-1:0] rf_write_index;
    logic [DATA_W-1:0] rf_write_data;
    logic              proto_err;

    modport master (
        output alu_valid, alu_index, alu_data,
        output ld_valid, ld_index, ld_data,
        output issue_valid, issue_rd, chk_index1, chk_index2,
        input  alu_ready, ld_ready, issue_ready, hazard,
        input  rf_reg_write, rf_write_index, rf_write_data, proto_err
    );

    modport slave (
        input  alu_valid, alu_index, alu_data,
        input  ld_valid, ld_index, ld_data,
        input  issue_valid, issue_rd, chk_index1, chk_index2,
        output alu_ready, ld_ready, issue_ready, hazard,
        output rf_reg_write, rf_write_index, rf_write_data, proto_err
    );
endinterface
`default_nettype wire

// File: rtl/rf_writeback_arbiter_scoreboard.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_scoreboard : per-register pending-load busy bits, outstanding load count
// Rev 1.0
// ---------------------------------------------------------------------------
module rf_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int MAX_LD   = 4
) (
    input  wire logic              clk,
    input  wire logic              nRST,
    input  wire logic              issue_valid,
    input  wire logic [ADDR_W-1:0] issue_rd,
    output logic                   issue_ready,
    input  wire logic              ld_grant,
    input  wire logic [ADDR_W-1:0] ld_index,
    input  wire logic [ADDR_W-1:0] chk_index1,
    input  wire logic [ADDR_W-1:0] chk_index2,
    output logic                   hazard,
    output logic                   proto_err
);
    localparam int CNT_W = $clog2(MAX_LD + 1);

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_proto_err;
    logic                w_issue_fire;
    logic                w_err;

    // A second load to a still-pending destination would make WAW ordering ambiguous.
    assign issue_ready  = (r_cnt < CNT_W'(MAX_LD)) &&
                          !((issue_rd != '0) && r_busy[issue_rd]);
    assign w_issue_fire = issue_valid && issue_ready;
    assign hazard       = r_busy[chk_index1] | r_busy[chk_index2];
    assign proto_err    = r_proto_err;

    assign w_err = ld_grant &&
                   (((ld_index != '0) && !r_busy[ld_index]) || (r_cnt == '0));

    // Clear first so that a same-cycle set of the same index wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (ld_grant) begin
            w_busy_nxt[ld_index] = 1'b0;
        end
        if (w_issue_fire && (issue_rd != '0)) begin
            w_busy_nxt[issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_busy      <= '0;
            r_cnt       <= '0;
            r_proto_err <= 1'b0;
        end else begin
            r_busy <= w_busy_nxt;
            if (w_issue_fire && !ld_grant) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (ld_grant && !w_issue_fire && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
            if (w_err) begin
                r_proto_err <= 1'b1;
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/rf_writeback_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rf_writeback_arbiter : round-robin ALU/load share of the RF write port
// Rev 1.0
// ---------------------------------------------------------------------------
module rf_writeback_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_REGS = CPU_NUM_REGS,
    parameter int ADDR_W   = CPU_ADDR_W,
    parameter int DATA_W   = CPU_DATA_W,
    parameter int MAX_LD   = CPU_MAX_LD
) (
    input  wire logic         clk,
    input  wire logic         nRST,
    rf_writeback_arbiter_if.slave bus
);
    wb_req_t w_alu_req;
    wb_req_t w_ld_req;
    wb_req_t w_win;
    wb_src_t r_rr;
    logic    w_alu_grant;
    logic    w_ld_grant;
    logic    r_we;
    regidx_t r_idx;
    word_t   r_data;

    assign w_alu_req = '{valid: bus.alu_valid, index: bus.alu_index, data: bus.alu_data};
    assign w_ld_req  = '{valid: bus.ld_valid,  index: bus.ld_index,  data: bus.ld_data};

    assign w_ld_grant  = w_ld_req.valid  && (!w_alu_req.valid || (r_rr == WB_LD));
    assign w_alu_grant = w_alu_req.valid && (!w_ld_req.valid  || (r_rr == WB_ALU));
    assign w_win       = w_ld_grant ? w_ld_req : w_alu_req;

    assign bus.alu_ready      = w_alu_grant;
    assign bus.ld_ready       = w_ld_grant;
    assign bus.rf_reg_write   = r_we;
    assign bus.rf_write_index = r_idx;
    assign bus.rf_write_data  = r_data;

    // Register 0 requests still complete the handshake but never assert the write enable.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            r_rr   <= WB_LD;
            r_we   <= 1'b0;
            r_idx  <= '0;
            r_data <= '0;
        end else if (w_alu_grant || w_ld_grant) begin
            r_we   <= (w_win.index != '0);
            r_idx  <= w_win.index;
            r_data <= w_win.data;
            r_rr   <= w_alu_grant ? WB_LD : WB_ALU;
        end else begin
            r_we <= 1'b0;
        end
    end

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W),
        .MAX_LD   (MAX_LD)
    ) u_scoreboard (
        .clk         (clk),
        .nRST        (nRST),
        .issue_valid (bus.issue_valid),
        .issue_rd    (bus.issue_rd),
        .issue_ready (bus.issue_ready),
        .ld_grant    (w_ld_grant),
        .ld_index    (bus.ld_index),
        .chk_index1  (bus.chk_index1),
        .chk_index2  (bus.chk_index2),
        .hazard      (bus.hazard),
        .proto_err   (bus.proto_err)
    );
endmodule
`default_nettype wire

// File: tb/tb_rf_writeback_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rf_writeback_arbiter : scoreboard bench for the RF writeback arbiter
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_rf_writeback_arbiter;
    logic clk  = 1'b0;
    logic nRST = 1'b1;
    always #5 clk = ~clk;

    rf_writeback_arbiter_if #(.ADDR_W(5), .DATA_W(32)) bus ();

    rf_writeback_arbiter #(
        .NUM_REGS (32),
        .ADDR_W   (5),
        .DATA_W   (32),
        .MAX_LD   (4)
    ) dut (
        .clk  (clk),
        .nRST (nRST),
        .bus  (bus)
    );

    typedef struct {
        int          due;
        logic        we;
        logic [4:0]  idx;
        logic [31:0] data;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    logic [31:0] m_busy;
    int          m_cnt;
    logic        m_rr_ld;
    logic        m_perr;
    logic        obs_alu, obs_ld, obs_iss, obs_haz, obs_perr, obs_we;
    logic [4:0]  obs_idx;
    logic [31:0] obs_data;
    logic        g_alu, g_ld;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic idle();
        bus.alu_valid   = 1'b0; bus.alu_index = '0; bus.alu_data = '0;
        bus.ld_valid    = 1'b0; bus.ld_index  = '0; bus.ld_data  = '0;
        bus.issue_valid = 1'b0; bus.issue_rd  = '0;
        bus.chk_index1  = '0;   bus.chk_index2 = '0;
    endtask

    // One clock: compare at the falling edge, advance the reference model, resume after the rising edge.
    task automatic tick();
        logic e_alu, e_ld, e_iss, e_haz, fire;
        exp_t e;
        @(negedge clk);
        obs_alu  = bus.alu_ready;   obs_ld  = bus.ld_ready;
        obs_iss  = bus.issue_ready; obs_haz = bus.hazard;
        obs_perr = bus.proto_err;   obs_we  = bus.rf_reg_write;
        obs_idx  = bus.rf_write_index; obs_data = bus.rf_write_data;

        e_ld  = bus.ld_valid  && (!bus.alu_valid || m_rr_ld);
        e_alu = bus.alu_valid && (!bus.ld_valid  || !m_rr_ld);
        e_iss = (m_cnt < 4) && !((bus.issue_rd != 0) && m_busy[bus.issue_rd]);
        e_haz = m_busy[bus.chk_index1] | m_busy[bus.chk_index2];

        check_val("alu_ready", obs_alu, e_alu);
        check_val("ld_ready", obs_ld, e_ld);
        check_val("issue_ready", obs_iss, e_iss);
        check_val("hazard", obs_haz, e_haz);
        check_val("proto_err", obs_perr, m_perr);
        if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            check_val("wr_en", obs_we, e.we);
            if (e.we) begin
                check_val("wr_idx", obs_idx, e.idx);
                check_val("wr_data", obs_data, e.data);
            end
        end else begin
            check_val("wr_idle", obs_we, 0);
        end

        g_alu = e_alu;
        g_ld  = e_ld;
        fire  = bus.issue_valid && e_iss;
        if (e_ld) begin
            if (((bus.ld_index != 0) && !m_busy[bus.ld_index]) || (m_cnt == 0)) m_perr = 1'b1;
            exp_q.push_back('{cyc + 1, bus.ld_index != 0, bus.ld_index, bus.ld_data});
        end
        if (e_alu) exp_q.push_back('{cyc + 1, bus.alu_index != 0, bus.alu_index, bus.alu_data});
        if (e_ld) m_busy[bus.ld_index] = 1'b0;
        if (fire && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
        m_busy[0] = 1'b0;
        if (fire && !e_ld) m_cnt++;
        else if (e_ld && !fire && m_cnt > 0) m_cnt--;
        if (e_alu) m_rr_ld = 1'b1;
        else if (e_ld) m_rr_ld = 1'b0;

        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        #1;
        check_val("rst_we", bus.rf_reg_write, 0);
        check_val("rst_idx", bus.rf_write_index, 0);
        check_val("rst_data", bus.rf_write_data, 0);
        check_val("rst_perr", bus.proto_err, 0);
        exp_q.delete();
        m_busy = '0; m_cnt = 0; m_rr_ld = 1'b1; m_perr = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nRST = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        #2;
        do_reset();
        tick();

        // Single ALU write and its one-cycle write pulse
        bus.alu_valid = 1'b1; bus.alu_index = 5'd5; bus.alu_data = 32'hDEADBEEF;
        tick();
        check_val("t1_alu_ready", obs_alu, 1);
        idle();
        tick();
        check_val("t1_we", obs_we, 1);
        check_val("t1_idx", obs_idx, 5);
        check_val("t1_data", obs_data, 32'hDEADBEEF);
        tick();
        check_val("t1_we_drop", obs_we, 0);

        // Register 0 is swallowed; zero data is still written
        bus.alu_valid = 1'b1; bus.alu_index = 5'd0; bus.alu_data = 32'h1234;
        tick();
        check_val("z0_ready", obs_alu, 1);
        idle();
        tick();
        check_val("z0_no_write", obs_we, 0);
        bus.alu_valid = 1'b1; bus.alu_index = 5'd9; bus.alu_data = 32'h0;
        tick();
        idle();
        tick();
        check_val("zd_we", obs_we, 1);
        check_val("zd_idx", obs_idx, 9);
        check_val("zd_data", obs_data, 0);

        // Scoreboard: hazard, WAW block, release on load writeback
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
        tick();
        check_val("sb_issue4", obs_iss, 1);
        bus.issue_valid = 1'b0; bus.chk_index1 = 5'd4;
        tick();
        check_val("sb_hazard4", obs_haz, 1);
        bus.issue_valid = 1'b1;
        tick();
        check_val("sb_waw_block", obs_iss, 0);
        bus.issue_valid = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_index = 5'd4; bus.ld_data = 32'hAAAA0004;
        tick();
        bus.ld_valid = 1'b0;
        tick();
        check_val("sb_hazard_clr", obs_haz, 0);
        check_val("sb_issue_again", obs_iss, 1);
        check_val("sb_no_err", obs_perr, 0);
        idle();

        // Capacity and simultaneous issue + load grant
        for (int r = 1; r <= 4; r++) begin
            bus.issue_valid = 1'b1; bus.issue_rd = 5'(r);
            tick();
            check_val("cap_issue", obs_iss, 1);
        end
        bus.issue_rd = 5'd5;
        tick();
        check_val("cap_full", obs_iss, 0);
        bus.issue_valid = 1'b0;
        bus.ld_valid = 1'b1; bus.ld_index = 5'd4; bus.ld_data = 32'h44;
        tick();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
        bus.ld_index = 5'd1; bus.ld_data = 32'h11;
        tick();
        check_val("cap_sim_issue", obs_iss, 1);
        check_val("cap_sim_ld", obs_ld, 1);
        idle();
        bus.chk_index1 = 5'd1; bus.chk_index2 = 5'd5;
        tick();
        check_val("cap_busy5", obs_haz, 1);
        bus.chk_index2 = 5'd0;
        tick();
        check_val("cap_busy1_clr", obs_haz, 0);
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd6;
        tick();
        check_val("cap_cnt3_room", obs_iss, 1);
        bus.issue_rd = 5'd7;
        tick();
        check_val("cap_cnt4_full", obs_iss, 0);
        idle();

        // Protocol error: load writeback to a register with no pending load
        bus.ld_valid = 1'b1; bus.ld_index = 5'd8; bus.ld_data = 32'h88;
        tick();
        idle();
        tick();
        check_val("err_write", obs_we, 1);
        check_val("err_idx", obs_idx, 8);
        check_val("err_flag", obs_perr, 1);
        tick();
        check_val("err_sticky", obs_perr, 1);

        // Contention right after reset: LD, ALU, LD, ALU
        do_reset();
        bus.alu_valid = 1'b1; bus.alu_index = 5'd3; bus.alu_data = 32'hA000;
        bus.ld_valid  = 1'b1; bus.ld_index  = 5'd7; bus.ld_data  = 32'hB000;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("cont_ld_grant", obs_ld, (i % 2) == 0);
            check_val("cont_alu_grant", obs_alu, (i % 2) == 1);
            if (i > 0) check_val("cont_wr_idx", obs_idx, ((i % 2) == 1) ? 7 : 3);
            if (g_ld)  bus.ld_data  = bus.ld_data + 1;
            if (g_alu) bus.alu_data = bus.alu_data + 1;
        end
        idle();
        tick();
        check_val("cont_last_idx", obs_idx, 3);
        tick();

        // Reset while a write is on the port; nothing may follow release
        bus.alu_valid = 1'b1; bus.alu_index = 5'd6; bus.alu_data = 32'h66;
        tick();
        idle();
        check_val("mg_pre_we", bus.rf_reg_write, 1);
        do_reset();
        repeat (3) tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
